// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch and load/store paths.
// Data has fixed priority over fetch, but a waiting fetch is forced through after
// STARVE_MAX consecutive data grants. Only one transaction is in flight at a time,
// and every output is driven straight from a flop.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no transaction in flight; arbitrate on every edge
// ST_ISSUE   | mem_req held with the latched fields until mem_ready
// ST_WAIT_RD | read accepted; waiting for mem_rvalid to route rdata
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              pick_d;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Data wins any contest unless fetch has been passed over STARVE_MAX times.
    pick_d      = d_req && !(if_req && (starve_q == STARVE_LIM));

    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_D;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          if (if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (if_req) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_IF;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_be_d    = {BE_W{1'b1}};
          starve_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          // A store is complete at acceptance; only loads wait for data.
          state_d   = mem_we_q ? ST_IDLE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester tasks push expected memory transactions
// and read data into per-port queues; a memory model pops and compares them.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } txn_t;

  txn_t          exp_if_mem[$];
  txn_t          exp_d_mem[$];
  logic [DW-1:0] exp_if_rd[$];
  logic [DW-1:0] exp_d_rd[$];
  bit            gnt_order[$];
  bit            glog[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ready_lat = 0;
  int rv_lat    = 1;
  bit force_rvalid = 1'b0;
  int cyc = 0;
  int if_rv_cnt = 0, d_rv_cnt = 0, req_cyc = 0;
  int if_gnt_cyc = 0, if_rv_cyc = 0;
  bit starve_exp [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic do_fetch(input logic [AW-1:0] a);
    txn_t t;
    bit   got;
    got     = 1'b0;
    t.we    = 1'b0;
    t.addr  = a;
    t.wdata = '0;
    t.be    = {BW{1'b1}};
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = a;
    exp_if_mem.push_back(t);
    exp_if_rd.push_back(rdata_of(a));
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (if_gnt) begin got = 1'b1; break; end
    end
    if_req = 1'b0;
    chk("if_gnt_seen", got, 1);
  endtask

  task automatic do_data(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    txn_t t;
    bit   got;
    got     = 1'b0;
    t.we    = we;
    t.addr  = a;
    t.wdata = wd;
    t.be    = be;
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
    exp_d_mem.push_back(t);
    if (!we) exp_d_rd.push_back(rdata_of(a));
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (d_gnt) begin got = 1'b1; break; end
    end
    d_req = 1'b0;
    chk("d_gnt_seen", got, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_if_rd.size() == 0 && exp_d_rd.size() == 0 &&
          gnt_order.size() == 0 && !if_req && !d_req) break;
    end
    chk("drain", 64'(busy) + 64'(exp_if_rd.size() + exp_d_rd.size() + gnt_order.size() +
        exp_if_mem.size() + exp_d_mem.size()), 0);
  endtask

  // Grant/response monitor plus memory model, all sampled at the falling edge
  initial begin
    bit            acc, acc_we, rd_pend, have_cur, cur_port;
    int            rv_wait, wait_cnt;
    logic [DW-1:0] rd_data;
    txn_t          cur;
    acc = 0; acc_we = 0; rd_pend = 0; have_cur = 0; cur_port = 0;
    rv_wait = 0; wait_cnt = 0; rd_data = '0; cur = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        exp_if_mem.delete(); exp_d_mem.delete();
        exp_if_rd.delete();  exp_d_rd.delete();
        gnt_order.delete();
        acc = 0; rd_pend = 0; have_cur = 0; wait_cnt = 0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
      end else begin
        chk("gnt_exclusive", if_gnt & d_gnt, 0);
        if (d_gnt) begin
          gnt_order.push_back(1'b1); glog.push_back(1'b1);
        end else if (if_gnt) begin
          gnt_order.push_back(1'b0); glog.push_back(1'b0); if_gnt_cyc = cyc;
        end
        if (if_rvalid) begin
          if_rv_cnt++; if_rv_cyc = cyc;
          if (exp_if_rd.size() > 0) chk("if_rdata", if_rdata, exp_if_rd.pop_front());
          else chk("if_rvalid_unexpected", if_rvalid, 0);
        end
        if (d_rvalid) begin
          d_rv_cnt++;
          if (exp_d_rd.size() > 0) chk("d_rdata", d_rdata, exp_d_rd.pop_front());
          else chk("d_rvalid_unexpected", d_rvalid, 0);
        end
        if (mem_req) req_cyc++;

        mem_ready  = 1'b0;
        mem_rvalid = force_rvalid;
        if (acc) begin
          acc = 0;
          chk("req_drop_after_accept", mem_req, 0);
          if (acc_we) chk("busy_after_write", busy, 0);
          else begin rd_pend = 1; rv_wait = rv_lat; end
        end
        if (rd_pend) begin
          chk("req_in_wait_rd", mem_req, 0);
          rv_wait--;
          if (rv_wait <= 0) begin
            mem_rvalid = 1'b1; mem_rdata = rd_data; rd_pend = 0;
          end
        end else if (mem_req) begin
          if (!have_cur) begin
            chk("req_has_grant", 64'(gnt_order.size() == 0), 0);
            if (gnt_order.size() > 0) begin
              cur_port = gnt_order.pop_front();
              if (cur_port) begin
                chk("exp_d_txn", 64'(exp_d_mem.size() == 0), 0);
                if (exp_d_mem.size() > 0) begin cur = exp_d_mem.pop_front(); have_cur = 1; end
              end else begin
                chk("exp_if_txn", 64'(exp_if_mem.size() == 0), 0);
                if (exp_if_mem.size() > 0) begin cur = exp_if_mem.pop_front(); have_cur = 1; end
              end
              wait_cnt = 0;
            end
          end
          if (have_cur) begin
            chk("mem_we", mem_we, cur.we);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_be", mem_be, cur.be);
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            if (wait_cnt >= ready_lat) begin
              mem_ready = 1'b1; acc = 1; acc_we = cur.we; have_cur = 0;
              if (!cur.we) rd_data = rdata_of(cur.addr);
            end else begin
              wait_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, v0;
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_rvalids", {if_rvalid, d_rvalid}, 0);
    chk("rst_mem_fields", {mem_we, mem_addr, mem_be, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single fetch: latency and routing
    ready_lat = 0; rv_lat = 1; d0 = d_rv_cnt; v0 = if_rv_cnt;
    do_fetch(32'h100);
    wait_idle();
    chk("fetch_latency", if_rv_cyc - if_gnt_cyc, 2);
    chk("fetch_if_rvalid_cnt", if_rv_cnt - v0, 1);
    chk("fetch_no_d_rvalid", d_rv_cnt - d0, 0);

    // Store with memory stalling two cycles
    ready_lat = 2; d0 = d_rv_cnt; r0 = req_cyc;
    do_data(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'h3);
    wait_idle();
    chk("store_req_cycles", req_cyc - r0, 3);
    chk("store_no_d_rvalid", d_rv_cnt - d0, 0);

    // Simultaneous requests from the same edge: data first
    ready_lat = 0; glog.delete();
    fork
      do_fetch(32'h400);
      do_data(1'b0, 32'h3000, '0, '0);
    join
    wait_idle();
    chk("sim_grants", glog.size(), 2);
    chk("sim_first_data", glog[0], 1);
    chk("sim_second_fetch", glog[1], 0);

    // Starvation: four data grants, then the held fetch is forced
    glog.delete();
    fork
      do_fetch(32'h500);
      begin
        for (int k = 0; k < 6; k++) do_data(1'b0, 32'h4000 + 32'(4 * k), '0, '0);
      end
    join
    wait_idle();
    chk("starve_grants", glog.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("starve_order_%0d", i), glog[i], starve_exp[i]);

    // Counter cleared by the fetch grant: data wins the next contest again
    glog.delete();
    fork
      do_fetch(32'h600);
      do_data(1'b0, 32'h5000, '0, '0);
    join
    wait_idle();
    chk("post_starve_data_first", glog[0], 1);

    // Back-to-back loads and fetches with read data two cycles after accept
    rv_lat = 2;
    fork
      begin
        do_data(1'b0, 32'h6000, '0, '0);
        do_data(1'b0, 32'h6004, '0, '0);
        do_data(1'b0, 32'h6008, '0, '0);
      end
      begin
        do_fetch(32'h700);
        do_fetch(32'h704);
      end
    join
    wait_idle();

    // Reset asserted while waiting for read data
    rv_lat = 6;
    do_fetch(32'h300);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("busy_in_wait_rd", busy, 1);
    reset = 1'b0;
    #1;
    chk("rst_rd_mem_req", mem_req, 0);
    chk("rst_rd_busy", busy, 0);
    chk("rst_rd_rvalids", {if_rvalid, d_rvalid}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    v0 = if_rv_cnt + d_rv_cnt;
    @(posedge clk); #1;
    force_rvalid = 1'b1;
    @(posedge clk); #1;
    force_rvalid = 1'b0;
    repeat (5) @(negedge clk);
    chk("late_rvalid_ignored", if_rv_cnt + d_rv_cnt - v0, 0);
    chk("late_rdata_untouched", {if_rdata, d_rdata}, 0);
    chk("late_busy", busy, 0);

    // Reset asserted while a store is stalled in issue
    ready_lat = 20;
    do_data(1'b1, 32'h7000, 32'h1234_5678, 4'hF);
    chk("req_before_rst", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rst_issue_mem_req", mem_req, 0);
    chk("rst_issue_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Normal operation resumes after reset
    ready_lat = 0; rv_lat = 1;
    do_fetch(32'h100);
    wait_idle();
    chk("resume_if_rdata", if_rdata, 32'h0050_0093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
